// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C codec-control target.
// State encoding covers the optional read path (I2C_TARGET_READ_EN) as well.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_BYTE0,
    ST_ACK0,
    ST_BYTE1,
    ST_ACK1,
    ST_EXTRA,
    ST_IGNORE,
    ST_READ_TX,
    ST_READ_ACK
  } state_t;

  localparam logic [6:0] CODEC_RESET_REG  = 7'h0F;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1a;
  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the asynchronous SCL/SDA levels and derives edge, START and STOP pulses.
// A START/STOP is only reported while SCL is stable high across both compared samples.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES:0] scl_pipe;
  logic [SYNC_STAGES:0] sda_pipe;
  logic scl_cur, scl_prev, sda_cur, sda_prev, scl_high;

  // Idle bus is high, so resetting to 1 avoids phantom edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-1:0], scl_in};
      sda_pipe <= {sda_pipe[SYNC_STAGES-1:0], sda_in};
    end
  end

  assign scl_cur  = scl_pipe[SYNC_STAGES-1];
  assign scl_prev = scl_pipe[SYNC_STAGES];
  assign sda_cur  = sda_pipe[SYNC_STAGES-1];
  assign sda_prev = sda_pipe[SYNC_STAGES];
  assign scl_high = scl_cur & scl_prev;

  assign sda      = sda_cur;
  assign scl_rise = scl_cur & ~scl_prev;
  assign scl_fall = ~scl_cur & scl_prev;
  assign start    = scl_high & sda_prev & ~sda_cur;
  assign stop     = scl_high & ~sda_prev & sda_cur;

endmodule

// File: rtl/i2c_codec_target.sv
// I2C target standing in for the codec control port: 3-byte writes into a 9-bit register file.
// Define I2C_TARGET_READ_EN to answer reads of the last addressed register.
module i2c_codec_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_reg,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_idx,
  output logic [8:0] rd_data,
  output logic       busy
);

  state_t     state, next_state;
  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [6:0] word_reg;
  logic       word_d8;
  logic [8:0] regs [NUM_REGS];
  logic       shift_en, cnt_inc, cnt_clr, latch_b0, commit;
  logic       byte_done, addr_match, resp_bit;

`ifdef I2C_TARGET_READ_EN
  logic [7:0] tx_byte;
  logic       tx_second, master_ack, load_tx, tx_shift, sample_mack;
  logic [6:0] last_reg;
  logic [8:0] last_data;
`endif

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

  assign byte_done  = scl_fall && (bit_cnt == 4'd8);
  assign addr_match = (shreg[7:1] == DEV_ADDR);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    latch_b0   = 1'b0;
    commit     = 1'b0;
`ifdef I2C_TARGET_READ_EN
    load_tx     = 1'b0;
    tx_shift    = 1'b0;
    sample_mack = 1'b0;
`endif
    if (stop_det) begin
      next_state = ST_IDLE;
      cnt_clr    = 1'b1;
    end else if (start_det) begin
      next_state = ST_ADDR;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        ST_ADDR, ST_BYTE0, ST_BYTE1: begin
          if (scl_rise && bit_cnt != 4'd8) shift_en = 1'b1;
          if (byte_done) begin
            if (state == ST_BYTE0) begin
              next_state = ST_ACK0;
              latch_b0   = 1'b1;
            end else if (state == ST_BYTE1) begin
              next_state = ST_ACK1;
            end else if (addr_match && shreg[0] == 1'b0) begin
              next_state = ST_ADDR_ACK;
`ifdef I2C_TARGET_READ_EN
            end else if (addr_match) begin
              next_state = ST_ADDR_ACK;
`endif
            end else begin
              next_state = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          cnt_clr = 1'b1;
`ifdef I2C_TARGET_READ_EN
          if (shreg[0]) begin
            next_state = ST_READ_TX;
            load_tx    = 1'b1;
          end else begin
            next_state = ST_BYTE0;
          end
`else
          next_state = ST_BYTE0;
`endif
        end
        ST_ACK0: if (scl_fall) begin
          next_state = ST_BYTE1;
          cnt_clr    = 1'b1;
        end
        ST_ACK1: if (scl_fall) begin
          next_state = ST_EXTRA;
          cnt_clr    = 1'b1;
          commit     = 1'b1;
        end
        // Extra bytes are counted only to stay aligned; the 9th clock is left un-ACKed.
        ST_EXTRA: if (scl_rise) begin
          if (bit_cnt == 4'd8) cnt_clr = 1'b1;
          else                 cnt_inc = 1'b1;
        end
`ifdef I2C_TARGET_READ_EN
        ST_READ_TX: begin
          if (scl_rise && bit_cnt != 4'd8) cnt_inc = 1'b1;
          if (scl_fall) begin
            if (bit_cnt == 4'd8) next_state = ST_READ_ACK;
            else                 tx_shift   = 1'b1;
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) sample_mack = 1'b1;
          if (scl_fall) begin
            if (master_ack == ACK && !tx_second) begin
              next_state = ST_READ_TX;
              load_tx    = 1'b1;
              cnt_clr    = 1'b1;
            end else begin
              next_state = ST_IGNORE;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // resp_bit is the level the target wants on SDA; open-drain can only pull it low.
  always_comb begin
    resp_bit = NACK;
    if (state inside {ST_ADDR_ACK, ST_ACK0, ST_ACK1}) resp_bit = ACK;
`ifdef I2C_TARGET_READ_EN
    if (state == ST_READ_TX) resp_bit = tx_byte[7];
`endif
  end

  assign sda_oe = (resp_bit == ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      word_reg <= '0;
      word_d8  <= 1'b0;
      wr_valid <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (cnt_clr)                  bit_cnt <= '0;
      else if (shift_en || cnt_inc) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) shreg <= {shreg[6:0], sda_s};
      if (latch_b0) {word_reg, word_d8} <= shreg;
      if (commit) begin
        wr_valid <= 1'b1;
        wr_reg   <= word_reg;
        wr_data  <= {word_d8, shreg};
        if (word_reg == CODEC_RESET_REG) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_REGS; i++)
            if (32'(word_reg) == i) regs[i] <= {word_d8, shreg};
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(rd_idx) == i) rd_data = regs[i];
  end

`ifdef I2C_TARGET_READ_EN
  always_comb begin
    last_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(last_reg) == i) last_data = regs[i];
  end

  // First read byte carries d[8] in its LSB, second byte carries d[7:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_byte    <= '0;
      tx_second  <= 1'b0;
      master_ack <= NACK;
      last_reg   <= '0;
    end else begin
      if (latch_b0)    last_reg   <= shreg[7:1];
      if (sample_mack) master_ack <= sda_s;
      if (load_tx) begin
        if (state == ST_ADDR_ACK) begin
          tx_byte   <= {7'b0, last_data[8]};
          tx_second <= 1'b0;
        end else begin
          tx_byte   <= last_data[7:0];
          tx_second <= 1'b1;
        end
      end else if (tx_shift) begin
        tx_byte <= {tx_byte[6:0], 1'b0};
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2c_codec_target.sv
// Self-checking bench for i2c_codec_target: bit-banged I2C master, open-drain SDA,
// write scoreboard plus a register-file model compared through rd_idx/rd_data.
module tb_i2c_codec_target;

  localparam int Q = 8;

  logic       clk, reset, scl, msda, sda_line;
  logic       sda_oe, wr_valid, busy;
  logic [6:0] wr_reg;
  logic [8:0] wr_data, rd_data;
  logic [3:0] rd_idx;

  typedef struct packed {
    logic [6:0] r;
    logic [8:0] d;
  } wr_exp_t;

  wr_exp_t    exp_q[$];
  logic [8:0] model_regs [16];
  int         n_compared;
  int         n_mismatched;

  assign sda_line = msda & ~sda_oe;

  i2c_codec_target dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    msda = 1'b1; wait_q(Q);
    scl  = 1'b1; wait_q(Q);
    msda = 1'b0; wait_q(Q);
    scl  = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    msda = 1'b0; wait_q(Q);
    scl  = 1'b1; wait_q(Q);
    msda = 1'b1; wait_q(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      msda = b[7-i]; wait_q(Q);
      scl  = 1'b1;   wait_q(2*Q);
      scl  = 1'b0;   wait_q(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8);
    msda  = 1'b1; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    acked = (sda_line == 1'b0);
    wait_q(Q);
    scl   = 1'b0; wait_q(Q);
  endtask

  task automatic expect_write(input logic [7:0] b0, input logic [7:0] b1);
    wr_exp_t e;
    e.r = b0[7:1];
    e.d = {b0[0], b1};
    exp_q.push_back(e);
    if (e.r == 7'h0F) begin
      for (int i = 0; i < 16; i++) model_regs[i] = '0;
    end else if (e.r < 7'd16) begin
      model_regs[e.r[3:0]] = e.d;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] addr_byte, input logic [7:0] b0, input logic [7:0] b1,
                                input bit extra, input bit accept);
    logic a;
    i2c_start();
    send_byte(addr_byte, a);
    check_output("addr_ack", a, accept);
    if (accept) expect_write(b0, b1);
    send_byte(b0, a);
    check_output("b0_ack", a, accept);
    send_byte(b1, a);
    check_output("b1_ack", a, accept);
    if (extra) begin
      send_byte(8'hFF, a);
      check_output("extra_ack", a, 1'b0);
    end
    i2c_stop();
    wait_q(4);
    check_output("busy_after_stop", busy, 1'b0);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      check_output($sformatf("rd_data[%0d]", i), rd_data, model_regs[i]);
    end
  endtask

  // Scoreboard side: every write-accept pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_valid) begin
      if (exp_q.size() == 0) begin
        check_output("wr_unexpected", 1, 0);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check_output("wr_reg", wr_reg, e.r);
        check_output("wr_data", wr_data, e.d);
      end
    end
  end

  initial begin
    #20000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic a;
    n_compared   = 0;
    n_mismatched = 0;
    reset  = 1'b1;
    scl    = 1'b1;
    msda   = 1'b1;
    rd_idx = '0;
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    wait_q(4);
    reset = 1'b0;
    wait_q(4);
    check_output("rst_sda_oe", sda_oe, 1'b0);
    check_output("rst_wr_valid", wr_valid, 1'b0);
    check_output("rst_wr_reg", wr_reg, 7'h00);
    check_output("rst_wr_data", wr_data, 9'h000);
    check_output("rst_busy", busy, 1'b0);
    check_regs();

    $display("[TB] plain writes");
    apply_stimulus(8'h34, 8'h04, 8'h0A, 1'b0, 1'b1);
    apply_stimulus(8'h34, 8'h0D, 8'h33, 1'b0, 1'b1);
    check_regs();

    $display("[TB] codec reset register");
    apply_stimulus(8'h34, 8'h1E, 8'h00, 1'b0, 1'b1);
    check_regs();
    apply_stimulus(8'h34, 8'h04, 8'h0A, 1'b0, 1'b1);
    check_regs();

    $display("[TB] foreign address and out-of-range register");
    apply_stimulus(8'h36, 8'h04, 8'h77, 1'b0, 1'b0);
`ifndef I2C_TARGET_READ_EN
    apply_stimulus(8'h35, 8'h06, 8'h77, 1'b0, 1'b0);
`endif
    apply_stimulus(8'h34, 8'h40, 8'h99, 1'b0, 1'b1);
    check_regs();

    $display("[TB] stop after first data byte");
    i2c_start();
    send_byte(8'h34, a);
    check_output("partial_addr_ack", a, 1'b1);
    send_byte(8'h06, a);
    check_output("partial_b0_ack", a, 1'b1);
    check_output("busy_mid_txn", busy, 1'b1);
    i2c_stop();
    wait_q(4);
    check_output("busy_after_partial", busy, 1'b0);
    check_regs();

    $display("[TB] repeated start inside second data byte");
    i2c_start();
    send_byte(8'h34, a);
    send_byte(8'h04, a);
    send_bits(8'h0A, 4);
    apply_stimulus(8'h34, 8'h05, 8'h55, 1'b0, 1'b1);
    check_regs();

    $display("[TB] four-byte write");
    apply_stimulus(8'h34, 8'h08, 8'h11, 1'b1, 1'b1);
    check_regs();

    $display("[TB] reset in the middle of the address byte");
    i2c_start();
    send_bits(8'h34, 4);
    check_output("busy_in_addr", busy, 1'b1);
    reset = 1'b1;
    wait_q(1);
    check_output("midrst_sda_oe", sda_oe, 1'b0);
    check_output("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    check_output("midrst_wr_reg", wr_reg, 7'h00);
    i2c_stop();
    wait_q(4);
    apply_stimulus(8'h34, 8'h0C, 8'hA5, 1'b0, 1'b1);
    check_regs();

    wait_q(10);
    check_output("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
